// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: NUM_IN-way selector feeding a STAGES-deep register chain with
// valid tracking, stall (hold every stage) and flush (invalidate every stage).
// Lets select logic cross a stage boundary, e.g. EX forwarding into EX/MEM.
//
// Parameters:
//   WIDTH   data width in bits
//   NUM_IN  number of data inputs (2..16)
//   SEL_W   select width, 2**SEL_W >= NUM_IN
//   STAGES  register stages after the mux (1..4)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_bus     flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel        input index
//   in_valid   qualifies the current selection
//   stall      hold every stage, discard the presented input
//   flush      invalidate every stage, overrides stall
//   out        data from the last stage
//   out_valid  valid from the last stage
//   sel_err    sticky illegal-select flag (SEL_PIPE_CHECK_EN builds only)
//
// Optional feature macro: SEL_PIPE_CHECK_EN
//   defined   : out-of-range sel with in_valid on a capturing edge sets
//               sel_err; that entry's data is zeroed but its valid propagates.
//   undefined : out-of-range sel falls through to input NUM_IN-1, no flag.

module sel_pipe_mux #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned STAGES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid
`ifdef SEL_PIPE_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  localparam int unsigned LAST = STAGES - 1;

  // Pipeline storage: one data word and one valid bit per stage.
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES-1:0] stage_vld;

  // Combinational pick; anything not matching an input index falls through
  // to the last input, mirroring the final-else of the legacy muxes.
  logic [WIDTH-1:0] pick_c;

  always_comb begin
    pick_c = in_bus[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int unsigned k = 0; k < NUM_IN - 1; k++) begin
      if (32'(sel) == k) begin
        pick_c = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Data presented to stage 0.
  logic [WIDTH-1:0] stage0_data_c;

`ifdef SEL_PIPE_CHECK_EN
  logic in_range_c;
  logic illegal_c;

  always_comb begin
    in_range_c    = (32'(sel) < 32'(NUM_IN));
    illegal_c     = in_valid && !in_range_c;
    // Out-of-range entries carry zero data so a bad index is never forwarded.
    stage0_data_c = in_range_c ? pick_c : '0;
  end

  // Sticky error flag, cleared only by rst or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sel_err <= 1'b0;
    end else if (!stall && illegal_c) begin
      sel_err <= 1'b1;
    end
  end
`else
  always_comb begin
    stage0_data_c = pick_c;
  end
`endif

  // Stage 0: captures the picked value every unstalled edge; valid qualifies it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stage_data[0] <= '0;
      stage_vld[0]  <= 1'b0;
    end else if (!stall) begin
      stage_data[0] <= stage0_data_c;
      stage_vld[0]  <= in_valid;
    end
  end

  // Stages 1..STAGES-1: plain shift, same clear/hold priority as stage 0.
  for (genvar s = 1; s < STAGES; s++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        stage_data[s] <= '0;
        stage_vld[s]  <= 1'b0;
      end else if (!stall) begin
        stage_data[s] <= stage_data[s-1];
        stage_vld[s]  <= stage_vld[s-1];
      end
    end
  end

  // Outputs come straight from the last stage's flops.
  assign out       = stage_data[LAST];
  assign out_valid = stage_vld[LAST];

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Self-checking bench for sel_pipe_mux.
// dut_a: NUM_IN=4, STAGES=3 (latency, stall, flush, reset, random stream).
// dut_b: NUM_IN=3, SEL_W=2, STAGES=2 (out-of-range select behaviour).
// Expected dut_a outputs are queued when a capturing input is driven and
// popped whenever the DUT presents a newly advanced valid output.

module tb_sel_pipe_mux;

  localparam int unsigned W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [1:0]        sel;
  logic [W-1:0]      in_a [4];
  logic [4*W-1:0]    in_bus_a;
  logic [3*W-1:0]    in_bus_b;
  logic [W-1:0]      out_a;
  logic              out_valid_a;
  logic [W-1:0]      out_b;
  logic              out_valid_b;
`ifdef SEL_PIPE_CHECK_EN
  logic              sel_err_a;
  logic              sel_err_b;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [W-1:0] exp_q [$];
  logic        mon_en = 1'b0;
  logic        last_hold = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) in_bus_a[k*W +: W] = in_a[k];
  end

  assign in_bus_b = {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};

  sel_pipe_mux #(.WIDTH(W), .NUM_IN(4), .SEL_W(2), .STAGES(3)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus_a),
    .sel       (sel),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .out       (out_a),
    .out_valid (out_valid_a)
`ifdef SEL_PIPE_CHECK_EN
    ,
    .sel_err   (sel_err_a)
`endif
  );

  sel_pipe_mux #(.WIDTH(W), .NUM_IN(3), .SEL_W(2), .STAGES(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus_b),
    .sel       (sel),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .out       (out_b),
    .out_valid (out_valid_b)
`ifdef SEL_PIPE_CHECK_EN
    ,
    .sel_err   (sel_err_b)
`endif
  );

  // Remember whether the last edge was a pure stall (output held, not advanced).
  always @(posedge clk) last_hold = stall && !flush && !rst;

  // Scoreboard monitor for dut_a.
  always @(negedge clk) begin
    if (mon_en && out_valid_a === 1'b1 && !last_hold) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: out=%h valid=1, expected no valid entry", out_a);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_a !== e) begin
          n_fail++;
          $display("FAIL sb_data: out=%h expected %h", out_a, e);
        end
      end
    end
  end

  // One clock of stimulus; queues the expected value if this edge captures.
  task automatic drive(input logic v, input logic [1:0] s, input logic st,
                       input logic fl, input logic r);
    in_valid = v; sel = s; stall = st; flush = fl; rst = r;
    if (v && !st && !fl && !r) exp_q.push_back(in_a[s]);
    @(posedge clk); #1;
    if (fl || r) exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_base_inputs();
    in_a[0] = 24'h000011; in_a[1] = 24'h000022;
    in_a[2] = 24'h000033; in_a[3] = 24'h000044;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = 2'd0;
    set_base_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++; if (out_a !== 24'h0) begin n_fail++; $display("FAIL reset_out_a: out=%h expected 000000", out_a); end
    n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: valid=%b expected 0", out_valid_a); end
    n_tests++; if (out_b !== 24'h0) begin n_fail++; $display("FAIL reset_out_b: out=%h expected 000000", out_b); end
    n_tests++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: valid=%b expected 0", out_valid_b); end
`ifdef SEL_PIPE_CHECK_EN
    n_tests++; if (sel_err_a !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err_a: sel_err=%b expected 0", sel_err_a); end
    n_tests++; if (sel_err_b !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err_b: sel_err=%b expected 0", sel_err_b); end
`endif
    mon_en = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One valid entry with sel=2; valid only after exactly 3 edges, for one cycle.
  task automatic test_latency();
    set_base_inputs();
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      else        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_valid_a !== (c == 3)) begin
        n_fail++;
        $display("FAIL latency_valid_edge%0d: valid=%b expected %b", c, out_valid_a, (c == 3));
      end
      if (c == 3) begin
        n_tests++;
        if (out_a !== 24'h000033) begin
          n_fail++;
          $display("FAIL latency_data: out=%h expected 000033", out_a);
        end
      end
    end
    idle(1);
  endtask

  // sel 0..3 streamed, stalled 2 cycles mid-stream; output must hold steady.
  task automatic test_stall();
    logic [W-1:0] held;
    set_base_inputs();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    held = out_a;
    n_tests++;
    if (out_valid_a !== 1'b1 || out_a !== 24'h000011) begin
      n_fail++;
      $display("FAIL stall_pre: out=%h valid=%b expected 000011 valid=1", out_a, out_valid_a);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_valid_a !== 1'b1 || out_a !== held) begin
        n_fail++;
        $display("FAIL stall_hold%0d: out=%h valid=%b expected %h valid=1", i, out_a, out_valid_a, held);
      end
    end
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(5);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: %0d entries outstanding, expected 0", exp_q.size());
    end
  endtask

  // Flush together with stall empties the chain; nothing stale after release.
  task automatic test_flush_stall();
    set_base_inputs();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid_a !== 1'b0 || out_a !== 24'h0) begin
      n_fail++;
      $display("FAIL flush_out: out=%h valid=%b expected 000000 valid=0", out_a, out_valid_a);
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_valid_a !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale%0d: valid=%b expected 0", i, out_valid_a);
      end
    end
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_reload: %0d entries outstanding, expected 0", exp_q.size());
    end
  endtask

  // rst pulse with two entries in flight: they never appear.
  task automatic test_reset_mid();
    set_base_inputs();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid%0d: valid=%b expected 0", i, out_valid_a);
      end
      drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // dut_b: 3 inputs on a 2-bit select, sel=3 is out of range.
  task automatic test_illegal_sel();
    logic [W-1:0] exp_ill;
`ifdef SEL_PIPE_CHECK_EN
    exp_ill = 24'h000000;
`else
    exp_ill = 24'hCCCCCC;
`endif
    set_base_inputs();
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid_b !== 1'b1 || out_b !== 24'hBBBBBB) begin
      n_fail++;
      $display("FAIL illegal_legal_pick: out=%h valid=%b expected bbbbbb valid=1", out_b, out_valid_b);
    end
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid_b !== 1'b1 || out_b !== exp_ill) begin
      n_fail++;
      $display("FAIL illegal_pick: out=%h valid=%b expected %h valid=1", out_b, out_valid_b, exp_ill);
    end
`ifdef SEL_PIPE_CHECK_EN
    n_tests++; if (sel_err_b !== 1'b1) begin n_fail++; $display("FAIL illegal_err_set: sel_err=%b expected 1", sel_err_b); end
    n_tests++; if (sel_err_a !== 1'b0) begin n_fail++; $display("FAIL illegal_err_a: sel_err=%b expected 0", sel_err_a); end
`endif
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_one_cycle: valid=%b expected 0", out_valid_b);
    end
    idle(3);
`ifdef SEL_PIPE_CHECK_EN
    @(negedge clk);
    n_tests++; if (sel_err_b !== 1'b1) begin n_fail++; $display("FAIL illegal_err_sticky: sel_err=%b expected 1", sel_err_b); end
`endif
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
`ifdef SEL_PIPE_CHECK_EN
    @(negedge clk);
    n_tests++; if (sel_err_b !== 1'b0) begin n_fail++; $display("FAIL illegal_err_flush: sel_err=%b expected 0", sel_err_b); end
`endif
    idle(1);
  endtask

  // Random back-to-back stream with occasional stalls, checked via scoreboard.
  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) in_a[k] = W'($urandom);
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), 1'b0, 1'b0);
    end
    idle(5);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d entries outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush_stall();
    test_reset_mid();
    test_illegal_sel();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_pipe_mux.md
# sel_pipe_mux

Parametrised N-input selector followed by a configurable-depth pipeline register chain with valid tracking, stall and flush. It generalises the two- and four-input result/forwarding muxes to any input count and width. It registers the selected value so select logic can move across a stage boundary between pipeline stages (e.g. EX-stage forwarding into the EX/MEM latch). Stall freezes the chain; flush inserts bubbles.

## Interface
- WIDTH, 24: data width in bits.
- NUM_IN, 4: number of data inputs, 2..16.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= NUM_IN.
- STAGES, 1: register stages after the mux, 1..4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_bus  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  input index.
- in_valid  in  1  qualifies the current selection.
- stall  in  1  hold every stage.
- flush  in  1  invalidate every stage.
- out  out  WIDTH  data from the last stage.
- out_valid  out  1  valid from the last stage.
- sel_err  out  1  sticky illegal-select flag; exists only with SEL_PIPE_CHECK_EN.

## Operation
- Combinational pick: in-range sel (< NUM_IN) selects input sel.
- Stage 0 captures {in_valid, picked data}. Stage s captures stage s-1. The last stage drives out/out_valid.
- Data is captured regardless of in_valid. Only the valid bit qualifies it.
- Priority per clock edge: rst > flush > stall > normal shift.
- rst: all stage data = 0, all valids = 0, sel_err = 0.
- flush: all stage data = 0 and all valids = 0 next cycle. The input presented in the flush cycle is discarded. flush overrides stall.
- stall (no flush): every stage, including stage 0, holds its data and valid. The input presented in that cycle is discarded.
- Out-of-range sel (NUM_IN < 2**SEL_W): without the macro, selects input NUM_IN-1. This matches the final-else fallthrough of the existing muxes.
- No internal state other than stage registers and sel_err. There is no FSM.

## Timing
- Latency: exactly STAGES cycles from an unstalled input edge to out; throughput 1 per cycle when stall = 0.
- Reset values: out = 0, out_valid = 0, sel_err = 0, all following the first rst edge.
- If rst is asserted mid-stream, all in-flight entries are lost at that edge. Normal capture resumes on the first edge with rst = 0.
- stall for k cycles adds exactly k cycles to the latency of every in-flight entry. out is stable during the stall.
- flush and stall together: the chain empties. When stall releases, the chain does not reload old data.
- out_valid deasserts on the edge following flush. It reasserts STAGES edges after the next unstalled in_valid = 1.
- in_valid, sel and in_bus are sampled only on the clock edge. No combinational path exists from any input to out or out_valid.

## Configuration
- SEL_PIPE_CHECK_EN defined:
  - Out-of-range sel with in_valid = 1 on an unstalled, unflushed edge sets sel_err (sticky).
  - That entry's data is forced to 0; its valid still propagates.
  - sel_err clears only on rst or flush.
- SEL_PIPE_CHECK_EN undefined:
  - sel_err port absent.
  - Out-of-range sel selects input NUM_IN-1, with no flagging.

## Test plan
- Reset: WIDTH=24, NUM_IN=4, STAGES=2, hold rst 2 cycles. Expect out = 0 and out_valid = 0. With the macro, expect sel_err = 0.
- Latency: STAGES=3, inputs 0x000011/0x000022/0x000033/0x000044, sel=2, in_valid=1 for one cycle. Expect out = 0x000033 with out_valid = 1 exactly 3 edges later, for one cycle.
- Stall: stream sel=0,1,2,3 back-to-back and assert stall for 2 cycles mid-stream. Expect the output sequence 0x11, 0x22, 0x33, 0x44 with a 2-cycle hold and no loss or duplication.
- Flush over stall: 2 valid entries in flight, assert flush and stall in the same cycle. Expect out_valid = 0 and out = 0 next edge, and no stale entry after stall releases.
- Illegal select: NUM_IN=3, SEL_W=2, sel=3, in_bus {0xAAAAAA, 0xBBBBBB, 0xCCCCCC}.
  - Without the macro: expect out = 0xCCCCCC.
  - With the macro: expect out = 0 with out_valid = 1, and sel_err = 1 until flush.
- Reset mid-stream: 2 valid entries in flight, pulse rst for one cycle. Expect out_valid = 0 next edge and never reasserted for those entries.
